// File: rtl/full_adder.sv
// full_adder: ripple-carry adder of per-bit full-adder cells with optional output register
`timescale 1ns/1ps
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  assign c[0] = CIN;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (.a(A[i]), .b(B[i]), .c(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  // registers always exist; when REG_OUT=0 they drive nothing and are trimmed
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum;
      cout_q <= c[WIDTH];
    end
  end
  assign S    = REG_OUT ? s_q : sum;
  assign COUT = REG_OUT ? cout_q : c[WIDTH];
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of combinational and registered adder configurations
`timescale 1ns/1ps
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;

  logic a1, b1, c1, s1, co1;
  logic [7:0] a8, b8, s8;
  logic c8, co8;
  logic ar, br, cr, sr, cor;
  logic [15:0] a16, b16, s16, s16r;
  logic c16, co16, co16r;

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u1 (.CLK(clk), .RST(rst), .CIN(c1), .A(a1), .B(b1), .S(s1), .COUT(co1));
  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u8 (.CLK(clk), .RST(rst), .CIN(c8), .A(a8), .B(b8), .S(s8), .COUT(co8));
  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1r (.CLK(clk), .RST(rst), .CIN(cr), .A(ar), .B(br), .S(sr), .COUT(cor));
  full_adder #(.WIDTH(16), .REG_OUT(1'b0)) u16 (.CLK(clk), .RST(rst), .CIN(c16), .A(a16), .B(b16), .S(s16), .COUT(co16));
  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u16r (.CLK(clk), .RST(rst), .CIN(c16), .A(a16), .B(b16), .S(s16r), .COUT(co16r));

  task automatic test_reset();
    @(negedge clk);
    {br, ar, cr} = 3'b111;
    {a16, b16, c16} = {16'hFFFF, 16'hFFFF, 1'b1};
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cor, sr} !== 2'b00) begin bad++; $display("FAIL reset_1b got=%b want=00", {cor, sr}); end
    total++;
    if ({co16r, s16r} !== 17'h0) begin bad++; $display("FAIL reset_16b got=%h want=0", {co16r, s16r}); end
    @(negedge clk);
    rst = 1'b0;
    {br, ar, cr} = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_truth_table();
    logic [7:0] s_tab = 8'b1001_0110;
    logic [7:0] c_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      {b1, a1, c1} = i[2:0];
      #25;
      total++;
      if ({s1, co1} !== {s_tab[i], c_tab[i]})
        begin bad++; $display("FAIL truth_%0d got S,COUT=%b%b want=%b%b", i, s1, co1, s_tab[i], c_tab[i]); end
      #25;
    end
  endtask

  task automatic test_carry_chain();
    logic [7:0] va [3] = '{8'hFF, 8'h80, 8'h5A};
    logic [7:0] vb [3] = '{8'h00, 8'h80, 8'h25};
    logic       vc [3] = '{1'b1, 1'b0, 1'b0};
    logic [8:0] ve [3] = '{9'h100, 9'h100, 9'h07F};
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; c8 = vc[i];
      #10;
      total++;
      if ({co8, s8} !== ve[i]) begin bad++; $display("FAIL chain_%0d got=%h want=%h", i, {co8, s8}, ve[i]); end
    end
  endtask

  task automatic test_reg_latency();
    @(negedge clk);
    {br, ar, cr} = 3'b111;
    #2;
    total++;
    if ({sr, cor} !== 2'b00) begin bad++; $display("FAIL lat_early got=%b want=00", {sr, cor}); end
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL lat_edge_n got=%b want=11", {sr, cor}); end
    @(negedge clk);
    {br, ar, cr} = 3'b000;
    #2;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL lat_hold got=%b want=11", {sr, cor}); end
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b00) begin bad++; $display("FAIL lat_edge_n1 got=%b want=00", {sr, cor}); end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    {br, ar, cr} = 3'b111;
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b want=11", {sr, cor}); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b00) begin bad++; $display("FAIL rst_clear got=%b want=00", {sr, cor}); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL rst_release got=%b want=11", {sr, cor}); end
    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL rst_glitch got=%b want=11", {sr, cor}); end
    @(posedge clk); #1;
    total++;
    if ({sr, cor} !== 2'b11) begin bad++; $display("FAIL rst_glitch_edge got=%b want=11", {sr, cor}); end
  endtask

  task automatic test_random();
    logic [16:0] exp;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      exp = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
      @(posedge clk); #1;
      total++;
      if ({co16, s16} !== exp) begin
        bad++;
        if (errs++ < 10) $display("FAIL rand_comb_%0d got=%h want=%h", i, {co16, s16}, exp);
      end
      total++;
      if ({co16r, s16r} !== exp) begin
        bad++;
        if (errs++ < 10) $display("FAIL rand_reg_%0d got=%h want=%h", i, {co16r, s16r}, exp);
      end
    end
  endtask

  initial begin
    {a1, b1, c1} = '0;
    {a8, b8, c8} = '0;
    {ar, br, cr} = '0;
    {a16, b16, c16} = '0;
    test_reset();
    test_truth_table();
    test_carry_chain();
    test_reg_latency();
    test_sync_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
